rom_load_sequencer: RTL and testbench
=====================================

// Module: rom_load_sequencer
// PURPOSE
//  Sequences HPS ROM download traffic (ioctl_*) into the game core's dn_* ROM write port.
//  Decodes each byte into one of three ROM regions and drops out-of-range bytes.
//  Owns the core reset: held during load and for a settle period after; released only after a complete load.
//  Sits between hps_io and the arcade core, in the clk_sys domain.
// PARAMETERS
//  R0_SIZE      16'h8000  bytes in region 0 (CPU ROM), addresses [0, R0_SIZE)
//  R1_SIZE      16'h4000  bytes in region 1 (GFX ROM), follows region 0
//  R2_SIZE      16'h1000  bytes in region 2 (sound/PROM), follows region 1
//  HOLD_CYCLES  16        core_reset hold after a good load, clk_sys cycles (>=1)
//  TOTAL = R0_SIZE+R1_SIZE+R2_SIZE; must not exceed 65536
// PORTS
//  clk_sys         in   1   system clock; all logic on rising edge
//  reset           in   1   synchronous, active-high
//  user_reset      in   1   OSD/button reset request, level
//  ioctl_download  in   1   HPS download active, level
//  ioctl_wr        in   1   one-cycle byte strobe
//  ioctl_addr      in   25  byte address
//  ioctl_dout      in   8   byte data
//  dn_wr           out  1   one-cycle ROM write strobe
//  dn_addr         out  16  region-relative address (ioctl_addr minus region base)
//  dn_data         out  8   write data
//  dn_region       out  3   one-hot region select, valid while dn_wr=1
//  core_reset      out  1   reset to core
//  rom_loaded      out  1   a complete load has finished
//  load_error      out  1   sticky: overflow byte or short load since last download start
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; dn_wr=0, dn_addr=0, dn_data=0, dn_region=0.
//   - core_reset=1, rom_loaded=0, load_error=0, byte_cnt=0, hold_cnt=0.
//  Edge detect: dl_q registers ioctl_download.
//   - rise = ioctl_download & ~dl_q; fall = ~ioctl_download & dl_q.
//  States:
//   - IDLE: core_reset=1. On rise -> LOAD.
//   - LOAD: core_reset=1. On fall -> HOLD if byte_cnt>=TOTAL, else IDLE with load_error set.
//   - HOLD: core_reset=1; hold_cnt decrements. At hold_cnt==1 -> RUN and set rom_loaded.
//   - RUN: core_reset = user_reset, registered (1-cycle latency). On rise -> LOAD.
//  Entering LOAD (rise in any state):
//   - Clear byte_cnt, load_error and rom_loaded.
//   - core_reset=1 on the cycle after rise.
//  Leaving LOAD for HOLD: load hold_cnt=HOLD_CYCLES.
//  Rise while in HOLD: abort the hold and restart LOAD.
//  Writes, accepted only in LOAD, or on the same cycle as the fall that leaves LOAD:
//   - Region by ioctl_addr: <R0_SIZE -> 3'b001; <R0+R1 -> 3'b010; <TOTAL -> 3'b100.
//   - Registered, latency 1: dn_wr high exactly one cycle after ioctl_wr.
//   - dn_addr = ioctl_addr - region base, truncated to 16 bits.
//   - byte_cnt increments, saturating at TOTAL. It counts strobes, not unique addresses.
//  Addresses >= TOTAL: no dn_wr, byte_cnt unchanged, load_error set (sticky).
//  ioctl_wr outside LOAD: ignored (dn_wr stays 0).
//  dn_addr, dn_data and dn_region hold their last values when dn_wr=0.
//  Reset mid-download: everything returns to reset values.
//   - If ioctl_download is still high after reset, a rise is seen on the next cycle -> LOAD restarts.
//  user_reset has no effect outside RUN, since core_reset is already 1.
// TESTING
//  1 Reset, then download TOTAL bytes with addr 0..TOTAL-1, then drop download:
//     -> TOTAL dn_wr pulses, each 1 cycle after ioctl_wr;
//     -> core_reset high for exactly HOLD_CYCLES after the fall, then 0;
//     -> rom_loaded=1, load_error=0.
//  2 Region boundaries: bytes at 0x7FFF, 0x8000, 0xBFFF, 0xC000:
//     -> dn_region 001/010/010/100;
//     -> dn_addr 0x7FFF/0x0000/0x3FFF/0x0000.
//  3 Extra byte at addr TOTAL (0xD000) inside a full load:
//     -> no dn_wr for it; load_error=1;
//     -> sequence still reaches RUN, since byte_cnt>=TOTAL.
//  4 Download stops after 100 bytes:
//     -> state IDLE, core_reset stays 1, rom_loaded=0, load_error=1.
//  5 ioctl_download rises again during HOLD, and again in RUN:
//     -> core_reset=1 the next cycle; rom_loaded clears; counters restart.
//     user_reset=1 for 3 cycles in RUN -> core_reset=1 for 3 cycles, delayed 1 cycle.
//  6 reset pulsed mid-LOAD with ioctl_download held high:
//     -> outputs at reset values;
//     -> LOAD re-entered the cycle after reset drops; ioctl_wr in the reset cycle produces no dn_wr.

Source files
------------

// File: rtl/rom_load_sequencer.sv
// Steers HPS ROM download bytes into three ROM regions and owns the core reset.
// The core reset is released only after a complete load plus a settle period.
module rom_load_sequencer #(
    parameter int unsigned R0_SIZE     = 32'h8000,
    parameter int unsigned R1_SIZE     = 32'h4000,
    parameter int unsigned R2_SIZE     = 32'h1000,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        user_reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        dn_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [2:0]  dn_region,
    output logic        core_reset,
    output logic        rom_loaded,
    output logic        load_error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam logic [24:0] R1_BASE   = 25'(R0_SIZE);
    localparam logic [24:0] R2_BASE   = 25'(R0_SIZE + R1_SIZE);
    localparam logic [24:0] TOTAL     = 25'(R0_SIZE + R1_SIZE + R2_SIZE);
    localparam logic [16:0] TOTAL_CNT = 17'(R0_SIZE + R1_SIZE + R2_SIZE);
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);

    state_t      state_q, state_d;
    logic        dl_q;
    logic [16:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        dn_wr_q, dn_wr_d;
    logic [15:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic [2:0]  dn_region_q, dn_region_d;
    logic        core_reset_q, core_reset_d;
    logic        rom_loaded_q, rom_loaded_d;
    logic        load_error_q, load_error_d;

    logic        rise;
    logic        fall;
    logic [2:0]  wr_region;
    logic [15:0] wr_offset;
    logic        wr_in_range;
    logic [16:0] byte_cnt_inc;

    assign rise = ioctl_download & ~dl_q;
    assign fall = ~ioctl_download & dl_q;

    // Region decode of the incoming byte address; all-zero region means out of range.
    always_comb begin
        wr_region = 3'b000;
        wr_offset = 16'h0000;
        if (ioctl_addr < R1_BASE) begin
            wr_region = 3'b001;
            wr_offset = 16'(ioctl_addr);
        end else if (ioctl_addr < R2_BASE) begin
            wr_region = 3'b010;
            wr_offset = 16'(ioctl_addr - R1_BASE);
        end else if (ioctl_addr < TOTAL) begin
            wr_region = 3'b100;
            wr_offset = 16'(ioctl_addr - R2_BASE);
        end
    end

    assign wr_in_range  = (wr_region != 3'b000);
    assign byte_cnt_inc = (byte_cnt_q < TOTAL_CNT) ? byte_cnt_q + 17'd1 : byte_cnt_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        dn_wr_d      = 1'b0;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        dn_region_d  = dn_region_q;
        rom_loaded_d = rom_loaded_q;
        load_error_d = load_error_q;

        case (state_q)
            ST_IDLE: begin
            end
            ST_LOAD: begin
                if (ioctl_wr) begin
                    if (wr_in_range) begin
                        dn_wr_d     = 1'b1;
                        dn_addr_d   = wr_offset;
                        dn_data_d   = ioctl_dout;
                        dn_region_d = wr_region;
                        byte_cnt_d  = byte_cnt_inc;
                    end else begin
                        load_error_d = 1'b1;
                    end
                end
                // A byte arriving with the falling edge still counts toward completeness.
                if (fall) begin
                    if (byte_cnt_d >= TOTAL_CNT) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_INIT;
                    end else begin
                        state_d      = ST_IDLE;
                        load_error_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q <= 16'd1) begin
                    state_d      = ST_RUN;
                    rom_loaded_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end
            ST_RUN: begin
            end
            default: state_d = ST_IDLE;
        endcase

        // A new download restarts the load from any state, aborting a pending hold.
        if (rise) begin
            state_d      = ST_LOAD;
            byte_cnt_d   = 17'd0;
            load_error_d = 1'b0;
            rom_loaded_d = 1'b0;
        end

        core_reset_d = (state_d == ST_RUN) ? user_reset : 1'b1;
    end

    // NOTE: state updates use non-blocking assignments; reset is sampled synchronously on the clock edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dl_q         <= 1'b0;
            byte_cnt_q   <= 17'd0;
            hold_cnt_q   <= 16'd0;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= 16'h0000;
            dn_data_q    <= 8'h00;
            dn_region_q  <= 3'b000;
            core_reset_q <= 1'b1;
            rom_loaded_q <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dl_q         <= ioctl_download;
            byte_cnt_q   <= byte_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dn_region_q  <= dn_region_d;
            core_reset_q <= core_reset_d;
            rom_loaded_q <= rom_loaded_d;
            load_error_q <= load_error_d;
        end
    end

    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_region  = dn_region_q;
    assign core_reset = core_reset_q;
    assign rom_loaded = rom_loaded_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer, built with region sizes scaled down 256x
// (0x80/0x40/0x10) so several complete loads fit in a short run.
module tb_rom_load_sequencer;

    localparam int R0    = 32'h80;
    localparam int R1    = 32'h40;
    localparam int R2    = 32'h10;
    localparam int HOLD  = 16;
    localparam int TOTAL = R0 + R1 + R2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        user_reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [2:0]  dn_region;
    logic        core_reset;
    logic        rom_loaded;
    logic        load_error;

    rom_load_sequencer #(
        .R0_SIZE     (R0),
        .R1_SIZE     (R1),
        .R2_SIZE     (R2),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .user_reset     (user_reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dn_wr          (dn_wr),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_region      (dn_region),
        .core_reset     (core_reset),
        .rom_loaded     (rom_loaded),
        .load_error     (load_error)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        logic [2:0]  exp_region;
        logic        exp_err;
    } vec_t;

    vec_t vecs [0:6];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [15:0] exp_off(input int a);
        if (a < R0)           return 16'(a);
        else if (a < R0 + R1) return 16'(a - R0);
        else                  return 16'(a - R0 - R1);
    endfunction

    function automatic logic [2:0] exp_reg(input int a);
        if (a < R0)           return 3'b001;
        else if (a < R0 + R1) return 3'b010;
        else                  return 3'b100;
    endfunction

    // Writes n in-range bytes from 'first', each followed by 'gap' idle cycles.
    task automatic load_bytes(input int first, input int n, input int gap,
                              output int pulses, output int bad);
        pulses = 0;
        bad    = 0;
        for (int i = 0; i < n; i++) begin
            int a;
            a = first + i;
            ioctl_addr = 25'(a);
            ioctl_dout = 8'(a) ^ 8'h5A;
            ioctl_wr   = 1'b1;
            tick();
            ioctl_wr   = 1'b0;
            if (dn_wr === 1'b1) pulses++;
            if (dn_wr !== 1'b1 || dn_addr !== exp_off(a) ||
                dn_data !== (8'(a) ^ 8'h5A) || dn_region !== exp_reg(a))
                bad++;
            for (int g = 0; g < gap; g++) begin
                tick();
                if (dn_wr !== 1'b0) bad++;
            end
        end
    endtask

    // Drops ioctl_download and counts how many sampled cycles core_reset stays high.
    task automatic measure_hold(output int hi);
        ioctl_download = 1'b0;
        tick();
        hi = 0;
        while (core_reset === 1'b1 && hi < 4 * HOLD) begin
            hi++;
            tick();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dn_wr"},      32'(dn_wr),      32'd0);
        check({tag, "_dn_addr"},    32'(dn_addr),    32'd0);
        check({tag, "_dn_data"},    32'(dn_data),    32'd0);
        check({tag, "_dn_region"},  32'(dn_region),  32'd0);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_rom_loaded"}, 32'(rom_loaded), 32'd0);
        check({tag, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    initial begin
        int pulses;
        int bad;
        int hi;

        vecs[0] = '{25'h000007F, 8'h11, 1'b1, 16'h007F, 8'h11, 3'b001, 1'b0};
        vecs[1] = '{25'h0000080, 8'h22, 1'b1, 16'h0000, 8'h22, 3'b010, 1'b0};
        vecs[2] = '{25'h00000BF, 8'h33, 1'b1, 16'h003F, 8'h33, 3'b010, 1'b0};
        vecs[3] = '{25'h00000C0, 8'h44, 1'b1, 16'h0000, 8'h44, 3'b100, 1'b0};
        vecs[4] = '{25'h00000D0, 8'h55, 1'b0, 16'h0000, 8'h44, 3'b100, 1'b1};
        vecs[5] = '{25'h00000CF, 8'h66, 1'b1, 16'h000F, 8'h66, 3'b100, 1'b1};
        vecs[6] = '{25'h1000005, 8'h77, 1'b0, 16'h000F, 8'h66, 3'b100, 1'b1};

        reset          = 1'b1;
        user_reset     = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b0;

        // Complete clean load, one byte every other cycle.
        ioctl_download = 1'b1;
        tick();
        check("t1_core_reset_load", 32'(core_reset), 32'd1);
        load_bytes(0, TOTAL, 1, pulses, bad);
        check("t1_pulse_errors", 32'(bad), 32'd0);
        check("t1_pulse_count", 32'(pulses), 32'(TOTAL));
        measure_hold(hi);
        check("t1_hold_len", 32'(hi), 32'(HOLD));
        check("t1_rom_loaded", 32'(rom_loaded), 32'd1);
        check("t1_load_error", 32'(load_error), 32'd0);

        // user_reset in RUN passes through with one cycle of latency.
        user_reset = 1'b1;
        check("ur_no_comb_path", 32'(core_reset), 32'd0);
        tick(); check("ur_c1", 32'(core_reset), 32'd1);
        tick(); check("ur_c2", 32'(core_reset), 32'd1);
        tick(); check("ur_c3", 32'(core_reset), 32'd1);
        user_reset = 1'b0;
        tick(); check("ur_c4", 32'(core_reset), 32'd0);

        // New download from RUN, stopped short after 100 bytes.
        ioctl_download = 1'b1;
        tick();
        check("run_rise_core_reset", 32'(core_reset), 32'd1);
        check("run_rise_rom_loaded", 32'(rom_loaded), 32'd0);
        load_bytes(0, 100, 0, pulses, bad);
        check("short_pulse_errors", 32'(bad), 32'd0);
        ioctl_download = 1'b0;
        tick();
        check("short_load_error", 32'(load_error), 32'd1);
        check("short_rom_loaded", 32'(rom_loaded), 32'd0);
        ioctl_addr = 25'h05;
        ioctl_dout = 8'hEE;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        check("idle_wr_ignored", 32'(dn_wr), 32'd0);
        check("idle_addr_held", 32'(dn_addr), 32'h63);
        repeat (HOLD + 8) tick();
        check("short_core_reset_stays", 32'(core_reset), 32'd1);

        // Region boundaries and out-of-range bytes, then finish a full load.
        ioctl_download = 1'b1;
        tick();
        check("reload_error_cleared", 32'(load_error), 32'd0);
        for (int i = 0; i < 7; i++) begin
            ioctl_addr = vecs[i].addr;
            ioctl_dout = vecs[i].data;
            ioctl_wr   = 1'b1;
            tick();
            ioctl_wr   = 1'b0;
            check($sformatf("vec%0d_wr", i),     32'(dn_wr),      32'(vecs[i].exp_wr));
            check($sformatf("vec%0d_addr", i),   32'(dn_addr),    32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_data", i),   32'(dn_data),    32'(vecs[i].exp_data));
            check($sformatf("vec%0d_region", i), 32'(dn_region),  32'(vecs[i].exp_region));
            check($sformatf("vec%0d_err", i),    32'(load_error), 32'(vecs[i].exp_err));
            tick();
            check($sformatf("vec%0d_wr_drop", i), 32'(dn_wr), 32'd0);
        end
        load_bytes(0, TOTAL, 0, pulses, bad);
        check("t3_pulse_errors", 32'(bad), 32'd0);
        check("t3_pulse_count", 32'(pulses), 32'(TOTAL));
        measure_hold(hi);
        check("t3_hold_len", 32'(hi), 32'(HOLD));
        check("t3_rom_loaded", 32'(rom_loaded), 32'd1);
        check("t3_load_error_sticky", 32'(load_error), 32'd1);

        // Rise during HOLD aborts the hold and restarts the load.
        ioctl_download = 1'b1;
        tick();
        load_bytes(0, TOTAL, 0, pulses, bad);
        ioctl_download = 1'b0;
        tick();
        repeat (5) tick();
        check("hold_mid_core_reset", 32'(core_reset), 32'd1);
        ioctl_download = 1'b1;
        tick();
        check("hold_rise_core_reset", 32'(core_reset), 32'd1);
        check("hold_rise_rom_loaded", 32'(rom_loaded), 32'd0);
        load_bytes(0, TOTAL, 0, pulses, bad);
        check("t5_pulse_errors", 32'(bad), 32'd0);
        check("t5_pulse_count", 32'(pulses), 32'(TOTAL));
        check("t5_core_reset_loading", 32'(core_reset), 32'd1);
        measure_hold(hi);
        check("t5_hold_len", 32'(hi), 32'(HOLD));
        check("t5_rom_loaded", 32'(rom_loaded), 32'd1);
        check("t5_load_error", 32'(load_error), 32'd0);

        // Reset mid-LOAD with ioctl_download held high and a write in the reset cycle.
        ioctl_download = 1'b1;
        tick();
        load_bytes(0, 10, 0, pulses, bad);
        reset      = 1'b1;
        ioctl_addr = 25'h20;
        ioctl_dout = 8'h99;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        check_reset_values("midrst");
        reset = 1'b0;
        tick();
        check("midrst_rise_core_reset", 32'(core_reset), 32'd1);
        check("midrst_rise_no_wr", 32'(dn_wr), 32'd0);
        ioctl_addr = 25'h41;
        ioctl_dout = 8'h77;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        check("midrst_reload_wr", 32'(dn_wr), 32'd1);
        check("midrst_reload_addr", 32'(dn_addr), 32'h41);
        check("midrst_reload_region", 32'(dn_region), 32'b001);
        ioctl_download = 1'b0;
        tick();
        check("midrst_short_error", 32'(load_error), 32'd1);
        check("midrst_short_rom_loaded", 32'(rom_loaded), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
